// File: rtl/lvds_frame_scheduler.sv
// Raster timing and per-frame pixel-source scheduler for the LVDS dot clock.
// Stage 0 holds the raster position and RAM read port; stage 1 holds the timed outputs.
module lvds_frame_scheduler #(
  parameter int unsigned H_ACTIVE = 1365,
  parameter int unsigned H_BLANK  = 50,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_BLANK  = 12,
  parameter int unsigned IMG_W    = 101,
  parameter int unsigned IMG_H    = 101,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk6x,
  input  logic              rst_n,
  input  logic              mode_req_valid,
  input  logic              mode_req,
  output logic              mode_ack,
  output logic              mode,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [23:0]       ram_rdata,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK + 1;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK + 1;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic          last_h, last_v, last_pix, apply;
  logic          mode_s0, mode_nxt, win_nxt;
  logic          pending, req_mode, applied, started, sel_ram;
  logic          active, top, hsync_c, vsync_c;
  logic [2:0]    bar;
  rgb_t          pix, rgb_q;

  // Next raster position and the source that position will use.
  always_comb begin : next_pos
    last_h   = (h == HW'(H_TOTAL - 1));
    last_v   = (v == VW'(V_TOTAL - 1));
    last_pix = last_h && last_v;
    apply    = last_pix && pending;
    h_nxt    = last_h ? '0 : h + HW'(1);
    v_nxt    = v;
    if (last_h) v_nxt = last_v ? '0 : v + VW'(1);
    mode_nxt = apply ? req_mode : mode_s0;
    win_nxt  = mode_nxt && (32'(h_nxt) < IMG_W) && (32'(v_nxt) < IMG_H)
               && (32'(v_nxt) < V_ACTIVE);
  end

  // Timing and colour decode of the current stage-0 position.
  always_comb begin : decode
    active = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    top    = (h == '0) && (v == '0);
    bar    = 3'd7;
    for (int k = 7; k >= 0; k--) begin
      if (32'(h) < 32'((k + 1) * H_ACTIVE / 8)) bar = 3'(k);
    end
    pix = '0;
    if (active) begin
      if (mode_s0) pix = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      else         pix = '{r: {8{bar[1]}}, g: {8{bar[2]}}, b: {8{bar[0]}}};
    end
    hsync_c = !((h > HW'(H_ACTIVE)) && (32'(h) < H_ACTIVE + H_BLANK / 2));
    vsync_c = !((v > VW'(V_ACTIVE)) && (32'(v) < V_ACTIVE + V_BLANK / 2));
  end

  // Window pixels are read in raster order, so the address simply counts up per read.
  always_ff @(posedge clk6x or negedge rst_n) begin : stage0
    if (!rst_n) begin
      h         <= '0;
      v         <= '0;
      mode_s0   <= 1'b0;
      pending   <= 1'b0;
      req_mode  <= 1'b0;
      applied   <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
    end else begin
      h         <= h_nxt;
      v         <= v_nxt;
      mode_s0   <= mode_nxt;
      applied   <= apply;
      if (apply) pending <= 1'b0;
      if (mode_req_valid) begin
        pending  <= 1'b1;
        req_mode <= mode_req;
      end
      ram_rd_en <= win_nxt;
      if (win_nxt) ram_addr <= last_pix ? '0 : ram_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk6x or negedge rst_n) begin : stage1
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_q       <= '0;
      sel_ram     <= 1'b0;
      frame_start <= 1'b0;
      mode_ack    <= 1'b0;
      mode        <= 1'b0;
      started     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      de          <= active;
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      rgb_q       <= pix;
      sel_ram     <= ram_rd_en;
      frame_start <= top;
      mode_ack    <= applied;
      mode        <= mode_s0;
      if (top) begin
        started <= 1'b1;
        if (started) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // RAM data arrives one cycle after the read, exactly when its pixel is in stage 1.
  assign {red, green, blue} = sel_ram ? ram_rdata : rgb_q;

endmodule

// File: tb/tb_lvds_frame_scheduler.sv
// Bench for lvds_frame_scheduler: directed raster/mode steps plus random mode strobes,
// every cycle compared against a position-arithmetic reference model.
module tb_lvds_frame_scheduler;

  localparam int H_ACTIVE = 1365;
  localparam int H_BLANK  = 50;
  localparam int V_ACTIVE = 3;
  localparam int V_BLANK  = 4;
  localparam int IMG_W    = 101;
  localparam int IMG_H    = 2;
  localparam int ADDR_W   = 14;
  localparam int H_TOTAL  = H_ACTIVE + H_BLANK + 1;
  localparam int V_TOTAL  = V_ACTIVE + V_BLANK + 1;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic              clk6x;
  logic              rst_n;
  logic              mode_req_valid;
  logic              mode_req;
  logic              mode_ack;
  logic              mode;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [23:0]       ram_rdata = '0;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              frame_start;
  logic [15:0]       frame_cnt;

  lvds_frame_scheduler #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk6x(clk6x), .rst_n(rst_n), .mode_req_valid(mode_req_valid), .mode_req(mode_req),
    .mode_ack(mode_ack), .mode(mode), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .hsync(hsync), .vsync(vsync), .de(de), .red(red),
    .green(green), .blue(blue), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  initial clk6x = 1'b0;
  always #5 clk6x = ~clk6x;

  // Image RAM with one cycle of read latency.
  logic [23:0] mem [0:(1 << ADDR_W) - 1];
  always @(posedge clk6x) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  int              asserts = 0;
  int              fails   = 0;
  int              n;
  bit              mpend;
  logic            mval;
  logic            mode_of [16];
  logic            ack_of [16];
  logic [ADDR_W-1:0] exp_addr;
  logic            prev_hs;
  int              hs_fall [$];
  int              hs_low = 0;
  int              ack_cnt = 0;
  int              a0;
  int              exp_low;

  function automatic int pos(input int f, input int v, input int h);
    return f * FRAME + v * H_TOTAL + h;
  endfunction

  function automatic logic [23:0] bar_rgb(input int h);
    logic [2:0] kk;
    for (int k = 0; k < 8; k++) begin
      if (h < (k + 1) * H_ACTIVE / 8) begin
        kk = 3'(k);
        return {{8{kk[1]}}, {8{kk[2]}}, {8{kk[0]}}};
      end
    end
    return 24'hFFFFFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    mpend    = 1'b0;
    mval     = 1'b0;
    exp_addr = '0;
    prev_hs  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mode_of[i] = 1'b0;
      ack_of[i]  = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sync_de"}, {hsync, vsync, de}, 3'b110);
    chk({tag, "_rgb"}, {red, green, blue}, 24'h0);
    chk({tag, "_ram"}, {ram_rd_en, ram_addr}, '0);
    chk({tag, "_flags"}, {frame_start, mode_ack, mode}, 3'b000);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
  endtask

  // Stage-1 outputs show position n-1, stage-0 RAM port shows position n.
  task automatic check_all();
    int p, f, r, h, v, f0, r0, h0, v0;
    logic de_e, hs_e, vs_e, rd_e;
    logic [23:0] rgb_e;
    logic [60:0] exp_v, obs_v;
    p = n - 1; f = p / FRAME; r = p % FRAME; h = r % H_TOTAL; v = r / H_TOTAL;
    de_e = (h < H_ACTIVE) && (v < V_ACTIVE);
    hs_e = !((h > H_ACTIVE) && (h < H_ACTIVE + H_BLANK / 2));
    vs_e = !((v > V_ACTIVE) && (v < V_ACTIVE + V_BLANK / 2));
    rgb_e = 24'h0;
    if (de_e) begin
      if (!mode_of[f])                 rgb_e = bar_rgb(h);
      else if (h < IMG_W && v < IMG_H) rgb_e = mem[v * IMG_W + h];
      else                             rgb_e = 24'hFF0000;
    end
    f0 = n / FRAME; r0 = n % FRAME; h0 = r0 % H_TOTAL; v0 = r0 / H_TOTAL;
    rd_e = mode_of[f0] && (h0 < IMG_W) && (v0 < IMG_H) && (v0 < V_ACTIVE);
    if (rd_e) exp_addr = ADDR_W'(v0 * IMG_W + h0);
    exp_v = {hs_e, vs_e, de_e, rgb_e, r == 0, (r == 0) && ack_of[f], mode_of[f],
             16'(f), rd_e, exp_addr};
    obs_v = {hsync, vsync, de, red, green, blue, frame_start, mode_ack, mode,
             frame_cnt, ram_rd_en, ram_addr};
    asserts++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL raster n=%0d v=%0d h=%0d observed %h expected %h", n, v, h, obs_v, exp_v);
    end
  endtask

  // One clock: strobe drive, frame-boundary mode model, then full output check.
  task automatic tick(input logic rv, input logic rq);
    int f0;
    f0 = n / FRAME;
    if (n % FRAME == FRAME - 1) begin
      mode_of[f0 + 1] = mpend ? mval : mode_of[f0];
      ack_of[f0 + 1]  = mpend;
      mpend = 1'b0;
    end
    if (rv) begin
      mpend = 1'b1;
      mval  = rq;
    end
    mode_req_valid = rv;
    mode_req       = rq;
    @(posedge clk6x);
    #1;
    n++;
    mode_req_valid = 1'b0;
    mode_req       = 1'b0;
    check_all();
    if (mode_ack) ack_cnt++;
    if (n <= H_TOTAL && !hsync) hs_low++;
    if (prev_hs && !hsync) hs_fall.push_back(n);
    prev_hs = hsync;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    mode_req_valid = 1'b0;
    mode_req = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 24'($urandom);
    exp_low = 0;
    for (int h = 0; h < H_TOTAL; h++)
      if (h > H_ACTIVE && h < H_ACTIVE + H_BLANK / 2) exp_low++;
    model_reset();
    repeat (3) @(posedge clk6x);
    #1;
    check_reset("por");
    rst_n = 1'b1;

    // Reset release and colour bars.
    tick(1'b0, 1'b0);
    chk("first_frame_start", frame_start, 1'b1);
    run_to(pos(0, 0, 169) + 1);
    chk("bar_h169", {red, green, blue}, 24'h000000);
    tick(1'b0, 1'b0);
    chk("bar_h170", {red, green, blue}, 24'h0000FF);
    run_to(pos(0, 0, 1364) + 1);
    chk("bar_h1364", {red, green, blue}, 24'hFFFFFF);
    tick(1'b0, 1'b0);
    chk("blank_h1365", {de, red, green, blue}, 25'h0);
    run_to(pos(0, 2, 0));
    chk("hsync_two_edges", hs_fall.size() >= 2, 1'b1);
    if (hs_fall.size() >= 2) chk("line_length", hs_fall[1] - hs_fall[0], H_TOTAL);
    chk("hsync_low_len", hs_low, exp_low);

    // Mid-frame request takes effect only at the boundary.
    run_to(pos(0, 2, 500));
    tick(1'b1, 1'b1);
    run_to(pos(1, 0, 0));
    chk("mode_held_to_end", {mode, mode_ack}, 2'b00);
    tick(1'b0, 1'b0);
    chk("apply_ack_with_fs", {frame_start, mode_ack, mode}, 3'b111);
    tick(1'b0, 1'b0);
    chk("ack_one_cycle", mode_ack, 1'b0);

    // Image window reads.
    run_to(pos(1, 1, 100));
    chk("img_addr_v1_h100", {ram_rd_en, ram_addr}, {1'b1, 14'd201});
    tick(1'b0, 1'b0);
    chk("img_rgb_word201", {red, green, blue}, mem[201]);
    chk("img_rd_off_h101", ram_rd_en, 1'b0);
    tick(1'b0, 1'b0);
    chk("img_outside_red", {red, green, blue}, 24'hFF0000);

    // Latest request wins, single ack.
    run_to(pos(1, 3, 10));
    tick(1'b1, 1'b1);
    run_to(pos(1, 5, 7));
    tick(1'b1, 1'b0);
    a0 = ack_cnt;
    run_to(pos(2, 0, 0));
    tick(1'b0, 1'b0);
    chk("latest_wins", {mode_ack, mode}, 2'b10);
    chk("frame_cnt_2", frame_cnt, 16'd2);
    run_to(pos(2, 1, 0));
    chk("single_ack", ack_cnt - a0, 1);

    // Same-mode request acks; a strobe on the apply cycle waits a frame.
    run_to(pos(2, 4, 3));
    tick(1'b1, 1'b0);
    run_to(pos(3, 0, 0) - 1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("same_mode_ack", {mode_ack, mode}, 2'b10);
    run_to(pos(4, 0, 0));
    tick(1'b0, 1'b0);
    chk("deferred_apply", {frame_start, mode_ack, mode}, 3'b111);
    chk("frame_cnt_4", frame_cnt, 16'd4);

    // Random strobes, then reset with a request pending.
    repeat (5000) tick($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)));
    tick(1'b1, 1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    @(posedge clk6x);
    @(posedge clk6x);
    #1;
    rst_n = 1'b1;
    model_reset();
    a0 = ack_cnt;
    tick(1'b0, 1'b0);
    chk("restart_fs", {frame_start, mode_ack, frame_cnt}, {1'b1, 1'b0, 16'd0});
    run_to(pos(1, 0, 0));
    tick(1'b0, 1'b0);
    chk("post_reset_boundary", {frame_start, mode_ack, mode, frame_cnt}, {3'b100, 16'd1});
    chk("no_ack_after_reset", ack_cnt - a0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
